// File: rtl/mlp_pkg.sv
// mlp_pkg: shared output-layer constants and the result-transmit state type
package mlp_pkg;

    localparam int DATA_W = 16;
    localparam int NUM_OUT = 10;
    localparam int ADDR_W = 12;
    localparam int RAM_AW = 4;
    localparam logic [ADDR_W-1:0] OUT_BASE_ADDR = 12'hC00;

    typedef enum logic [1:0] {IDLE, READ, WAIT, SEND} tx_state_e;

endpackage

// File: rtl/output_stream_tx.sv
// output_stream_tx: streams NUM_OUT output-neuron results from the result RAM to the classifier
module output_stream_tx #(
    parameter int NUM_OUT = mlp_pkg::NUM_OUT,
    parameter int DATA_W = mlp_pkg::DATA_W,
    parameter int ADDR_W = mlp_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = mlp_pkg::OUT_BASE_ADDR,
    parameter int RAM_AW = mlp_pkg::RAM_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [RAM_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);
    import mlp_pkg::tx_state_e;
    import mlp_pkg::IDLE;
    import mlp_pkg::READ;
    import mlp_pkg::WAIT;
    import mlp_pkg::SEND;

    localparam int K_W = $clog2(NUM_OUT);

    tx_state_e   state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // state, beat counter, captured result and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // one RAM read, one capture and one held beat per neuron; done stays set until the next start
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                k_d     = '0;
                done_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = READ;
            end
            READ: begin
                mem_rd_en = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                data_d  = mem_rd_data;
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (k_q == K_W'(NUM_OUT - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_addr = (state_q == READ) ? RAM_AW'(k_q) : '0;
    assign out_data    = data_q;
    assign out_addr    = BASE_ADDR + ADDR_W'(k_q);
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
